wb_grf: RTL and testbench

Writeback stage and general register file for the five-stage MIPS pipeline. It consumes the W-stage bundle latched by the M/W pipeline register (`W_pc`, `W_instr`, `W_aluans`, `W_dmrd`), decodes the destination register and writeback source, and commits the result to a 32x32 register file. It also serves the two D-stage read ports.

---
 rtl/wb_grf.sv | 117 +++++++++++
 tb/tb_wb_grf.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wb_grf.sv
// Writeback decode and 32x32 general register file for the MIPS pipeline.
// Optional `GRF_BYPASS_EN: read ports return the in-flight W-stage result for a matching address.
module wb_grf (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] W_pc,
    input  logic [31:0] W_instr,
    input  logic [31:0] W_aluans,
    input  logic [31:0] W_dmrd,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    output logic [31:0] D_rs_data,
    output logic [31:0] D_rt_data,
    output logic        W_we,
    output logic [4:0]  W_waddr,
    output logic [31:0] W_wdata
);

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_DM,
        SRC_PC8
    } wb_src_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    // $0 is not stored; reads of address 0 are forced to zero below.
    logic [31:0] rf_q [1:31];

    wb_src_e     src;
    logic [4:0]  dst;
    logic [31:0] wdata_raw;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    assign opcode = W_instr[31:26];
    assign funct  = W_instr[5:0];

    always_comb begin
        src = SRC_NONE;
        dst = '0;
        unique case (opcode)
            OP_RTYPE: begin
                if (funct == FN_ADD || funct == FN_SUB) begin
                    src = SRC_ALU;
                    dst = W_instr[15:11];
                end
            end
            OP_ORI, OP_LUI: begin
                src = SRC_ALU;
                dst = W_instr[20:16];
            end
            OP_LW: begin
                src = SRC_DM;
                dst = W_instr[20:16];
            end
            OP_JAL: begin
                src = SRC_PC8;
                dst = 5'd31;
            end
            default: begin
                src = SRC_NONE;
                dst = '0;
            end
        endcase
    end

    always_comb begin
        wdata_raw = '0;
        case (src)
            SRC_ALU: wdata_raw = W_aluans;
            SRC_DM:  wdata_raw = W_dmrd;
            SRC_PC8: wdata_raw = W_pc + 32'd8;
            default: wdata_raw = '0;
        endcase
        W_we    = (src != SRC_NONE) && (dst != 5'd0);
        W_waddr = W_we ? dst : '0;
        W_wdata = W_we ? wdata_raw : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 1; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (W_we) begin
            rf_q[W_waddr] <= W_wdata;
        end
    end

    function automatic logic [31:0] read_port(input logic [4:0] addr);
        logic [31:0] val;
        val = '0;
        if (addr != 5'd0) begin
`ifdef GRF_BYPASS_EN
            if (W_we && addr == W_waddr) val = W_wdata;
            else                         val = rf_q[addr];
`else
            val = rf_q[addr];
`endif
        end
        return val;
    endfunction

    always_comb begin
        D_rs_data = read_port(D_rs_addr);
        D_rt_data = read_port(D_rt_addr);
    end

endmodule

// File: tb/tb_wb_grf.sv
// Directed self-checking bench for wb_grf; expected values are hand-computed from the instruction encodings.
module tb_wb_grf;

    logic        clk;
    logic        reset;
    logic [31:0] W_pc;
    logic [31:0] W_instr;
    logic [31:0] W_aluans;
    logic [31:0] W_dmrd;
    logic [4:0]  D_rs_addr;
    logic [4:0]  D_rt_addr;
    logic [31:0] D_rs_data;
    logic [31:0] D_rt_data;
    logic        W_we;
    logic [4:0]  W_waddr;
    logic [31:0] W_wdata;

    int unsigned n_checks;
    int unsigned n_errors;

    wb_grf dut (
        .clk       (clk),
        .reset     (reset),
        .W_pc      (W_pc),
        .W_instr   (W_instr),
        .W_aluans  (W_aluans),
        .W_dmrd    (W_dmrd),
        .D_rs_addr (D_rs_addr),
        .D_rt_addr (D_rt_addr),
        .D_rs_data (D_rs_data),
        .D_rt_data (D_rt_data),
        .W_we      (W_we),
        .W_waddr   (W_waddr),
        .W_wdata   (W_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] alu,
                           input logic [31:0] dm, input logic [31:0] pc);
        W_instr  = instr;
        W_aluans = alu;
        W_dmrd   = dm;
        W_pc     = pc;
        #1;
    endtask

    task automatic read_rs(input logic [4:0] a, input string tag, input logic [31:0] exp);
        D_rs_addr = a;
        #1;
        check(tag, D_rs_data, exp);
    endtask

    task automatic read_rt(input logic [4:0] a, input string tag, input logic [31:0] exp);
        D_rt_addr = a;
        #1;
        check(tag, D_rt_data, exp);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        W_pc      = '0;
        W_instr   = '0;
        W_aluans  = '0;
        W_dmrd    = '0;
        D_rs_addr = '0;
        D_rt_addr = '0;

        // Reset, then sweep every address on both ports.
        step();
        reset = 1'b0;
        #1;
        check("rst_we", {31'd0, W_we}, 32'd0);
        check("rst_waddr", {27'd0, W_waddr}, 32'd0);
        check("rst_wdata", W_wdata, 32'd0);
        for (int i = 0; i < 32; i++) begin
            read_rs(5'(i), "rst_sweep_rs", 32'd0);
            read_rt(5'(i), "rst_sweep_rt", 32'd0);
        end

        // ori $8,$0,0x1234
        present(32'h3408_1234, 32'h0000_1234, 32'h0, 32'h0000_3000);
        check("ori_we", {31'd0, W_we}, 32'd1);
        check("ori_waddr", {27'd0, W_waddr}, 32'd8);
        check("ori_wdata", W_wdata, 32'h0000_1234);
        step();
        present(32'h0, 32'h0, 32'h0, 32'h0);
        read_rt(5'd8, "ori_read", 32'h0000_1234);

        // lw $9: data comes from memory, not ALU
        present(32'h8C09_0000, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0000_3004);
        check("lw_waddr", {27'd0, W_waddr}, 32'd9);
        check("lw_wdata", W_wdata, 32'hDEAD_BEEF);
        step();
        present(32'h0, 32'h0, 32'h0, 32'h0);
        read_rs(5'd9, "lw_read", 32'hDEAD_BEEF);

        // jal: $31 = pc + 8
        present(32'h0C00_0C00, 32'h1111_1111, 32'h2222_2222, 32'h0000_3010);
        check("jal_waddr", {27'd0, W_waddr}, 32'd31);
        check("jal_wdata", W_wdata, 32'h0000_3018);
        step();
        present(32'h0, 32'h0, 32'h0, 32'h0);
        read_rs(5'd31, "jal_read", 32'h0000_3018);

        // jal with pc wrap: carry dropped
        present(32'h0C00_0C00, 32'h0, 32'h0, 32'hFFFF_FFFC);
        check("jal_wrap_wdata", W_wdata, 32'h0000_0004);
        step();
        present(32'h0, 32'h0, 32'h0, 32'h0);
        read_rs(5'd31, "jal_wrap_read", 32'h0000_0004);

        // add $10 and sub $11 (R-type, rd destination)
        present(32'h0000_5020, 32'h0000_0077, 32'hFFFF_FFFF, 32'h0);
        check("add_waddr", {27'd0, W_waddr}, 32'd10);
        check("add_wdata", W_wdata, 32'h0000_0077);
        step();
        present(32'h0000_5822, 32'h8000_0001, 32'h0, 32'h0);
        check("sub_waddr", {27'd0, W_waddr}, 32'd11);
        step();
        present(32'h0, 32'h0, 32'h0, 32'h0);
        read_rs(5'd10, "add_read", 32'h0000_0077);
        read_rt(5'd11, "sub_read", 32'h8000_0001);

        // No-write cases: add $0, sw, jr, bubble
        present(32'h0000_0020, 32'h5555_5555, 32'h0, 32'h0);
        check("add0_we", {31'd0, W_we}, 32'd0);
        check("add0_wdata", W_wdata, 32'd0);
        step();
        present(32'hAC08_0000, 32'h6666_6666, 32'h7777_7777, 32'h0);
        check("sw_we", {31'd0, W_we}, 32'd0);
        check("sw_waddr", {27'd0, W_waddr}, 32'd0);
        step();
        present(32'h03E0_0008, 32'h8888_8888, 32'h0, 32'h0);
        check("jr_we", {31'd0, W_we}, 32'd0);
        step();
        present(32'h0, 32'h9999_9999, 32'h9999_9999, 32'h0);
        check("bubble_we", {31'd0, W_we}, 32'd0);
        step();
        read_rs(5'd0, "r0_read", 32'd0);
        read_rt(5'd8, "nowrite_r8", 32'h0000_1234);
        read_rs(5'd31, "nowrite_r31", 32'h0000_0004);

        // Same-cycle read of the write target: lui $8 with both ports on $8
        D_rs_addr = 5'd8;
        D_rt_addr = 5'd8;
        present(32'h3C08_ABCD, 32'hABCD_0000, 32'h0, 32'h0);
        check("lui_we", {31'd0, W_we}, 32'd1);
`ifdef GRF_BYPASS_EN
        check("same_cyc_rs", D_rs_data, 32'hABCD_0000);
        check("same_cyc_rt", D_rt_data, 32'hABCD_0000);
`else
        check("same_cyc_rs", D_rs_data, 32'h0000_1234);
        check("same_cyc_rt", D_rt_data, 32'h0000_1234);
`endif
        // Held for a second cycle: re-applied write is harmless
        step();
        step();
        present(32'h0, 32'h0, 32'h0, 32'h0);
        check("lui_next_rs", D_rs_data, 32'hABCD_0000);
        check("lui_next_rt", D_rt_data, 32'hABCD_0000);

        // Reset collides with a write to $5; reset wins and clears everything
        present(32'h3405_0005, 32'h0000_0005, 32'h0, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        present(32'h0, 32'h0, 32'h0, 32'h0);
        read_rs(5'd5, "rstcol_r5", 32'd0);
        read_rt(5'd8, "rstcol_r8", 32'd0);
        read_rs(5'd9, "rstcol_r9", 32'd0);

        // Write after reset still works
        present(32'h3405_0005, 32'h0000_0005, 32'h0, 32'h0);
        step();
        present(32'h0, 32'h0, 32'h0, 32'h0);
        read_rs(5'd5, "post_rst_r5", 32'h0000_0005);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
